// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared constants and types for the SRAM-backed streaming FIFO
package sram_fifo_pkg;
  localparam int DEF_BITS   = 16;
  localparam int DEF_DEPTH  = 4096;
  localparam int DEF_AW     = 12;
  localparam int SKID_DEPTH = 2;
  typedef logic [DEF_AW-1:0] ptr_t;
  typedef logic [DEF_AW:0]   cnt_t;
endpackage

// File: rtl/sram_fifo_skid.sv
// sram_fifo_skid: 2-entry register buffer absorbing the SRAM read latency
// Ports: push/din capture a returning read word, pop consumes the head,
// valid/dout present the head, cnt reports occupancy (0..2).
module sram_fifo_skid import sram_fifo_pkg::*; #(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [BITS-1:0] din,
  output logic            valid,
  output logic [BITS-1:0] dout,
  output logic [$clog2(SKID_DEPTH+1)-1:0] cnt
);
  logic [BITS-1:0] tail;
  logic wr_head, wr_tail, shift;
  // head only moves when a second entry exists, so an emptied buffer keeps its last word
  assign shift   = pop && cnt == 2'd2;
  assign wr_head = push && (cnt == 2'd0 || (cnt == 2'd1 && pop));
  assign wr_tail = push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop));
  assign valid   = cnt != 2'd0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      dout <= shift ? tail : wr_head ? din : dout;
      tail <= wr_tail ? din : tail;
      cnt  <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: streaming FIFO controller driving a dual-port fakeram_w16 SRAM macro
// Ports: s_valid/s_ready/s_data upstream write stream; m_valid/m_ready/m_data
// downstream read stream; count total occupancy; rw0_* write-port drive;
// rw1_* read-port drive with rw1_rd_out returning one cycle after a read.
// Define SRAM_FIFO_ALMOST_EN to add registered almost_full/almost_empty flags.
module sram_fifo_ctrl import sram_fifo_pkg::*; #(
  parameter int BITS       = DEF_BITS,
  parameter int WORD_DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_AW,
  parameter int AF_MARGIN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BITS-1:0]       s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BITS-1:0]       m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  rw0_ce_in,
  output logic                  rw0_we_in,
  output logic [ADDR_WIDTH-1:0] rw0_addr_in,
  output logic [BITS-1:0]       rw0_wd_in,
  output logic                  rw1_ce_in,
  output logic                  rw1_we_in,
  output logic [ADDR_WIDTH-1:0] rw1_addr_in,
  output logic [BITS-1:0]       rw1_wd_in,
  input  logic [BITS-1:0]       rw1_rd_out
`ifdef SRAM_FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(WORD_DEPTH);
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0] mem_cnt, count_nxt;
  logic [1:0] skid_cnt;
  logic [2:0] occ;
  logic inflight, push, pop, issue;
  assign s_ready   = rst_n && count < FULL;
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  // skid slots already claimed by buffered and in-flight words, after this cycle's pop
  assign occ       = {1'b0, skid_cnt} + {2'b0, inflight};
  assign issue     = rst_n && mem_cnt != '0 && occ < (pop ? 3'd3 : 3'd2);
  assign count_nxt = count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
  assign rw0_ce_in   = push;
  assign rw0_we_in   = push;
  assign rw0_addr_in = push ? wptr : '0;
  assign rw0_wd_in   = push ? s_data : '0;
  assign rw1_ce_in   = issue;
  assign rw1_we_in   = 1'b0;
  assign rw1_addr_in = issue ? rptr : '0;
  assign rw1_wd_in   = '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      wptr     <= wptr + ADDR_WIDTH'(push);
      rptr     <= rptr + ADDR_WIDTH'(issue);
      mem_cnt  <= mem_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      count    <= count_nxt;
      inflight <= issue;
    end
  end
  // clearing inflight on reset drops any read still returning from the macro
  sram_fifo_skid #(.BITS(BITS)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (rw1_rd_out),
    .valid (m_valid),
    .dout  (m_data),
    .cnt   (skid_cnt)
  );
`ifdef SRAM_FIFO_ALMOST_EN
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(WORD_DEPTH - AF_MARGIN);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
    end else begin
      almost_full  <= count_nxt >= AF_LEVEL;
      almost_empty <= count_nxt <= (ADDR_WIDTH+1)'(1);
    end
  end
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed self-checking bench for sram_fifo_ctrl with a behavioural SRAM macro
module tb_sram_fifo_ctrl;
  localparam int DEPTH = 4096;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, m_valid, rw0_ce_in, rw0_we_in, rw1_ce_in, rw1_we_in;
  logic [15:0] m_data, rw0_wd_in, rw1_wd_in;
  logic [15:0] rw1_rd_out = '0;
  logic [12:0] count;
  logic [11:0] rw0_addr_in, rw1_addr_in;
`ifdef SRAM_FIFO_ALMOST_EN
  logic almost_full, almost_empty;
`endif
  logic [15:0] mem [0:DEPTH-1];
  int checks = 0, errors = 0;

  sram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in), .rw0_addr_in(rw0_addr_in), .rw0_wd_in(rw0_wd_in),
    .rw1_ce_in(rw1_ce_in), .rw1_we_in(rw1_we_in), .rw1_addr_in(rw1_addr_in), .rw1_wd_in(rw1_wd_in),
    .rw1_rd_out(rw1_rd_out)
`ifdef SRAM_FIFO_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rw0_ce_in && rw0_we_in) mem[rw0_addr_in] <= rw0_wd_in;
    if (rw1_ce_in) rw1_rd_out <= mem[rw1_addr_in];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    #1;
  endtask

  initial begin
    int exp_o, n_in, model;
    logic [11:0] wexp, rexp;
    logic [15:0] held;
    bit stalled, seen, v, r, pu, po;
    // reset state, with s_valid high to show no write leaks through
    rst_n = 1'b0;
    drive(1, 16'h5555, 1);
    tick;
    tick;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_count", count, 0);
    chk("rst_rw0_ce", rw0_ce_in, 0);
    chk("rst_rw0_we", rw0_we_in, 0);
    chk("rst_rw0_addr", rw0_addr_in, 0);
    chk("rst_rw0_wd", rw0_wd_in, 0);
    chk("rst_rw1_ce", rw1_ce_in, 0);
    chk("rst_rw1_we", rw1_we_in, 0);
    chk("rst_rw1_wd", rw1_wd_in, 0);
    rst_n = 1'b1;
    drive(0, 0, 1);
    chk("release_s_ready", s_ready, 1);
    // single word: accept in cycle 0, present in cycle 3
    drive(1, 16'h1234, 1);
    chk("single_rw0_ce", rw0_ce_in, 1);
    chk("single_rw0_addr", rw0_addr_in, 0);
    chk("single_rw0_wd", rw0_wd_in, 16'h1234);
    tick;
    drive(0, 0, 1);
    chk("single_issue", rw1_ce_in, 1);
    chk("single_raddr", rw1_addr_in, 0);
    chk("single_count", count, 1);
    chk("single_c1_valid", m_valid, 0);
    tick;
    chk("single_c2_valid", m_valid, 0);
    tick;
    chk("single_c3_valid", m_valid, 1);
    chk("single_c3_data", m_data, 16'h1234);
    tick;
    chk("single_c4_valid", m_valid, 0);
    chk("single_c4_count", count, 0);
    chk("single_hold_data", m_data, 16'h1234);
`ifdef SRAM_FIFO_ALMOST_EN
    chk("almost_empty_0", almost_empty, 1);
    chk("almost_full_0", almost_full, 0);
`endif
    // fill to full with the sink stalled
    wexp = 12'd1;
    rexp = 12'd1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 16'(i), 0);
      chk("fill_s_ready", s_ready, 1);
      chk("fill_addr", rw0_addr_in, wexp);
`ifdef SRAM_FIFO_ALMOST_EN
      if (i == 4079) chk("almost_full_4079", almost_full, 0);
      if (i == 4080) chk("almost_full_4080", almost_full, 1);
      if (i == 2) chk("almost_empty_2", almost_empty, 0);
`endif
      wexp = wexp + 12'd1;
      tick;
    end
    drive(1, 16'hDEAD, 0);
    chk("full_s_ready", s_ready, 0);
    chk("full_count", count, DEPTH);
    chk("full_no_write", rw0_ce_in, 0);
    chk("full_m_valid", m_valid, 1);
    chk("full_head", m_data, 0);
    // drain in order; a pop at full reopens s_ready only on the next cycle
    exp_o = 0;
    for (int c = 0; c < 6000 && exp_o < DEPTH; c++) begin
      drive(0, 0, 1);
      if (c == 0) chk("full_pop_same_cycle", s_ready, 0);
      if (c == 1) chk("full_pop_next_cycle", s_ready, 1);
      if (m_valid) begin
        chk("drain_data", m_data, 16'(exp_o));
        exp_o++;
      end
      tick;
    end
    chk("drain_all", exp_o, DEPTH);
    chk("drain_count", count, 0);
    chk("drain_m_valid", m_valid, 0);
    rexp = rexp + 12'(DEPTH);
    // full-rate streaming across two pointer wraps
    n_in = 0;
    exp_o = 0;
    for (int c = 0; c < 10100 && exp_o < 10000; c++) begin
      drive(n_in < 10000, 16'(n_in), 1);
      if (n_in < 10000) begin
        chk("stream_s_ready", s_ready, 1);
        chk("stream_waddr", rw0_addr_in, wexp);
      end
      if (c == 2) chk("stream_lat_c2", m_valid, 0);
      if (c == 3) chk("stream_lat_c3", m_valid, 1);
      if (rw1_ce_in) begin
        chk("stream_raddr", rw1_addr_in, rexp);
        rexp = rexp + 12'd1;
      end
      if (exp_o > 0) chk("stream_no_bubble", m_valid, 1);
      if (m_valid) begin
        chk("stream_data", m_data, 16'(exp_o));
        exp_o++;
      end
      if (s_valid && s_ready) begin
        n_in++;
        wexp = wexp + 12'd1;
      end
      tick;
    end
    chk("stream_all", exp_o, 10000);
    chk("stream_count", count, 0);
    // random valid/ready with a count scoreboard and stall stability
    n_in = 0;
    exp_o = 0;
    model = 0;
    stalled = 0;
    held = '0;
    for (int c = 0; c < 40000 && exp_o < 5000; c++) begin
      v = (n_in < 5000) && ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 2) != 0;
      drive(v, 16'(n_in + 20000), r);
      if (stalled) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held);
      end
      pu = s_valid && s_ready;
      po = m_valid && m_ready;
      if (po) begin
        chk("rand_data", m_data, 16'(exp_o + 20000));
        exp_o++;
      end
      if (pu) n_in++;
      stalled = m_valid && !m_ready;
      held = m_data;
      model = model + int'(pu) - int'(po);
      tick;
      chk("rand_count", count, model);
    end
    chk("rand_all", exp_o, 5000);
    // reset mid-stream with count = 100 and a read in flight
    for (int i = 0; i < 100; i++) begin
      drive(1, 16'(i + 1000), 0);
      tick;
    end
    chk("pre_rst_count", count, 100);
    drive(1, 16'h7777, 1);
    chk("pre_rst_issue", rw1_ce_in, 1);
    tick;
    chk("pre_rst_count_hold", count, 100);
    rst_n = 1'b0;
    drive(0, 0, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_rw1_ce", rw1_ce_in, 0);
    chk("mid_rst_rw1_addr", rw1_addr_in, 0);
    tick;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rw0_addr", rw0_addr_in, 0);
    rst_n = 1'b1;
    drive(1, 16'hBEEF, 1);
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_waddr", rw0_addr_in, 0);
    tick;
    drive(0, 0, 1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (m_valid) begin
        seen = 1;
        chk("post_rst_first_word", m_data, 16'hBEEF);
      end else tick;
    end
    chk("post_rst_word_seen", seen, 1);
    tick;
    chk("post_rst_empty", count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
